// File: rtl/rib_timer.sv
// rib_timer: bus-mapped 32-bit timer with prescaler, compare match and interrupt.
// Ports: clk, rst_n, write bus (wr_req_i/addr/data), read bus (rd_req_i/addr, rd_data_o), int_o.
module rib_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h2000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_req_i,
  input  logic [31:0] wr_addr_i,
  input  logic [31:0] wr_data_i,
  input  logic        rd_req_i,
  input  logic [31:0] rd_addr_i,
  output logic [31:0] rd_data_o,
  output logic        int_o
);

  logic        en;
  logic        ie;
  logic        ar;
  logic [7:0]  psc;
  logic [31:0] presc;
  logic [31:0] value;
  logic [31:0] cmp;
  logic        pend;

  logic        wr_sel;
  logic        rd_sel;
  logic        wr_ctrl;
  logic        wr_value;
  logic        wr_cmp;
  logic        wr_status;
  logic        tick;
  logic        match;
  logic [31:0] rd_mux;
  logic        unused_addr;

  assign unused_addr = ^{wr_addr_i[1:0], rd_addr_i[1:0]};

  assign wr_sel = wr_req_i &&
    (wr_addr_i[31:4] == BASE_ADDR[31:4]);
  assign rd_sel = rd_addr_i[31:4] == BASE_ADDR[31:4];

  assign wr_ctrl   = wr_sel && (wr_addr_i[3:2] == 2'd0);
  assign wr_value  = wr_sel && (wr_addr_i[3:2] == 2'd1);
  assign wr_cmp    = wr_sel && (wr_addr_i[3:2] == 2'd2);
  assign wr_status = wr_sel && (wr_addr_i[3:2] == 2'd3);

  assign tick  = en && (presc == {24'd0, psc});
  assign match = tick && (value == cmp);

  assign int_o = pend & ie;

  always_comb begin
    rd_mux = 32'd0;
    unique case (rd_addr_i[3:2])
      2'd0: rd_mux = {16'd0, psc, 5'd0, ar, ie, en};
      2'd1: rd_mux = value;
      2'd2: rd_mux = cmp;
      2'd3: rd_mux = {31'd0, pend};
      default: rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en        <= 1'b0;
      ie        <= 1'b0;
      ar        <= 1'b0;
      psc       <= 8'd0;
      presc     <= 32'd0;
      value     <= 32'd0;
      cmp       <= 32'hFFFF_FFFF;
      pend      <= 1'b0;
      rd_data_o <= 32'd0;
    end else begin
      if (wr_ctrl) begin
        en  <= wr_data_i[0];
        ie  <= wr_data_i[1];
        ar  <= wr_data_i[2];
        psc <= wr_data_i[15:8];
      end else if (match && !ar) begin
        en <= 1'b0;
      end

      if (wr_ctrl || tick) begin
        presc <= 32'd0;
      end else if (en) begin
        presc <= presc + 32'd1;
      end

      if (wr_value) begin
        value <= wr_data_i;
      end else if (match) begin
        value <= 32'd0;
      end else if (tick) begin
        value <= value + 32'd1;
      end

      if (wr_cmp) begin
        cmp <= wr_data_i;
      end

      // hardware set beats a same-cycle software clear
      if (match) begin
        pend <= 1'b1;
      end else if (wr_status && wr_data_i[0]) begin
        pend <= 1'b0;
      end

      if (rd_req_i) begin
        rd_data_o <= rd_sel ? rd_mux : 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_rib_timer.sv
// tb_rib_timer: directed test of rib_timer with a cycle model and scoreboard.
// Checks int_o/rd_data_o every cycle plus literal register expectations.
module tb_rib_timer;

  localparam logic [31:0] BASE   = 32'h2000_0000;
  localparam logic [31:0] A_CTRL = BASE;
  localparam logic [31:0] A_VAL  = BASE + 32'd4;
  localparam logic [31:0] A_CMP  = BASE + 32'd8;
  localparam logic [31:0] A_ST   = BASE + 32'd12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_req = 1'b0;
  logic [31:0] wr_addr = 32'd0;
  logic [31:0] wr_data = 32'd0;
  logic        rd_req = 1'b0;
  logic [31:0] rd_addr = 32'd0;
  logic [31:0] rd_data;
  logic        irq;

  int total = 0;
  int bad = 0;

  rib_timer #(.BASE_ADDR(BASE)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_req_i (wr_req),
    .wr_addr_i(wr_addr),
    .wr_data_i(wr_data),
    .rd_req_i (rd_req),
    .rd_addr_i(rd_addr),
    .rd_data_o(rd_data),
    .int_o    (irq)
  );

  always #5 clk = ~clk;

  // behavioural model: timer state as plain numbers
  logic        m_en, m_ie, m_ar, m_pend;
  int unsigned m_psc, m_phase;
  logic [31:0] m_val, m_cmp, m_rd;

  function automatic logic [31:0] m_reg(input logic [1:0] o);
    case (o)
      2'd0: return {16'd0, m_psc[7:0], 5'd0, m_ar, m_ie, m_en};
      2'd1: return m_val;
      2'd2: return m_cmp;
      default: return {31'd0, m_pend};
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_en = 0; m_ie = 0; m_ar = 0; m_pend = 0;
      m_psc = 0; m_phase = 0;
      m_val = 0; m_cmp = 32'hFFFF_FFFF; m_rd = 0;
    end else begin
      logic hit, ws, tk;
      logic [1:0] wo;
      logic [31:0] nxt;
      ws = wr_req && (wr_addr[31:4] == BASE[31:4]);
      wo = wr_addr[3:2];
      if (rd_req)
        m_rd = (rd_addr[31:4] == BASE[31:4]) ?
          m_reg(rd_addr[3:2]) : 32'd0;
      tk  = m_en && (m_phase == m_psc);
      hit = tk && (m_val == m_cmp);
      nxt = hit ? 32'd0 : (tk ? m_val + 32'd1 : m_val);
      if (hit) m_pend = 1;
      else if (ws && wo == 2'd3 && wr_data[0]) m_pend = 0;
      if (hit && !m_ar) m_en = 0;
      if (m_en || tk) m_phase = tk ? 0 : m_phase + 1;
      if (ws && wo == 2'd1) nxt = wr_data;
      m_val = nxt;
      if (ws && wo == 2'd2) m_cmp = wr_data;
      if (ws && wo == 2'd0) begin
        m_en = wr_data[0]; m_ie = wr_data[1]; m_ar = wr_data[2];
        m_psc = wr_data[15:8]; m_phase = 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_int", {31'd0, irq}, {31'd0, m_pend & m_ie});
      chk("model_rd", rd_data, m_rd);
    end
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    wr_req = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_req = 1'b0;
  endtask

  task automatic rdchk(input string nm, input logic [31:0] a,
                       input logic [31:0] exp);
    rd_req = 1'b1; rd_addr = a;
    @(negedge clk);
    rd_req = 1'b0;
    chk(nm, rd_data, exp);
  endtask

  logic [31:0] seq30 [6] = '{0, 1, 2, 3, 0, 1};
  logic [31:0] seq31 [8] = '{0, 0, 1, 1, 2, 2, 0, 0};

  initial begin
    #1;
    chk("rst_rd", rd_data, 32'd0);
    chk("rst_int", {31'd0, irq}, 32'd0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rdchk("rst_ctrl", A_CTRL, 32'd0);
    rdchk("rst_cmp", A_CMP, 32'hFFFF_FFFF);
    rdchk("rst_val", A_VAL, 32'd0);
    rdchk("rst_st", A_ST, 32'd0);

    wr(A_CMP, 32'd3);
    wr(A_CTRL, 32'h7);
    for (int i = 0; i < 6; i++) begin
      rdchk("ar_val", A_VAL, seq30[i]);
      if (i == 4) chk("ar_int", {31'd0, irq}, 32'd1);
    end

    wr(A_CTRL, 32'h2);
    chk("w1c_pre_int", {31'd0, irq}, 32'd1);
    wr(A_ST, 32'd1);
    chk("w1c_int", {31'd0, irq}, 32'd0);
    rdchk("w1c_st", A_ST, 32'd0);
    wr(A_VAL, 32'd3);
    wr(A_CTRL, 32'h3);
    wr(A_ST, 32'd1);
    chk("race_int", {31'd0, irq}, 32'd1);
    rdchk("race_st", A_ST, 32'd1);
    rdchk("race_ctrl", A_CTRL, 32'h2);
    rdchk("race_val", A_VAL, 32'd0);

    wr(A_ST, 32'd1);
    wr(A_CMP, 32'd2);
    wr(A_CTRL, 32'h103);
    for (int i = 0; i < 8; i++)
      rdchk("os_val", A_VAL, seq31[i]);
    rdchk("os_ctrl", A_CTRL, 32'h102);
    rdchk("os_st", A_ST, 32'd1);

    rdchk("oor_10", BASE + 32'h10, 32'd0);
    rdchk("hold_src", A_CMP, 32'd2);
    @(negedge clk);
    chk("hold_rd", rd_data, 32'd2);
    rdchk("oor_hi", 32'h3000_0008, 32'd0);

    wr(A_ST, 32'd1);
    wr(A_CMP, 32'd5);
    wr(A_VAL, 32'hFFFF_FFFF);
    wr(A_CTRL, 32'h5);
    rdchk("wrap_pre", A_VAL, 32'hFFFF_FFFF);
    rdchk("wrap_val", A_VAL, 32'd0);
    rdchk("wrap_st", A_ST, 32'd0);
    wr(A_VAL, 32'h10);
    rdchk("swpri_val", A_VAL, 32'h10);
    wr(32'h3000_0008, 32'h7);
    rdchk("ign_cmp", A_CMP, 32'd5);

    wr(A_CTRL, 32'h7);
    wr(A_VAL, 32'd5);
    @(negedge clk);
    chk("mid_int", {31'd0, irq}, 32'd1);
    rdchk("mid_ctrl", A_CTRL, 32'h7);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_int", {31'd0, irq}, 32'd0);
    chk("arst_rd", rd_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rdchk("post_cmp", A_CMP, 32'hFFFF_FFFF);
    rdchk("post_ctrl", A_CTRL, 32'd0);
    rdchk("post_val", A_VAL, 32'd0);
    rdchk("post_val2", A_VAL, 32'd0);
    rdchk("post_st", A_ST, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/rib_timer.md
RIB_TIMER -- requirements
Module: rib_timer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h2000_0000: block selected when addr[31:4] == BASE_ADDR[31:4].
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port wr_req_i, input, 1: bus write request (core write request AND write enable).
REQ-005 SHALL have port wr_addr_i, input, 32: write byte address.
REQ-006 SHALL have port wr_data_i, input, 32: write data, full word only.
REQ-007 SHALL have port rd_req_i, input, 1: bus read request.
REQ-008 SHALL have port rd_addr_i, input, 32: read byte address.
REQ-009 SHALL have port rd_data_o, output, 32: registered read data.
REQ-010 SHALL have port int_o, output, 1: level interrupt to the core interrupt input.

Function
REQ-011 SHALL decode offset addr[3:2]: 0 = CTRL, 1 = VALUE, 2 = CMP, 3 = STATUS.
REQ-012 SHALL implement CTRL with these fields; unused bits read 0:
- bit0 EN
- bit1 IE
- bit2 AR (auto-reload)
- bits[15:8] PSC
REQ-013 SHALL implement a 32-bit prescaler counter that counts only while EN = 1 and produces one tick per PSC+1 cycles.
REQ-014 SHALL generate the tick in the cycle the prescaler equals PSC; the prescaler then wraps to 0 in that same cycle.
REQ-015 SHALL increment VALUE by 1 on each tick, wrapping 32'hFFFF_FFFF -> 0.
REQ-016 SHALL, on a tick when VALUE == CMP, do all of the following:
- set VALUE to 0 instead of incrementing;
- set STATUS bit0 (PEND);
- clear EN if AR = 0 (one-shot mode).
REQ-017 SHALL drive int_o = PEND & IE, computed from registered state only.
REQ-018 SHALL complete a selected write in one cycle; data is visible in the register on the next edge and no stall is generated.
REQ-019 SHALL treat a STATUS write as write-1-to-clear on bit0; all other STATUS bits are read-only 0.
REQ-020 SHALL clear the prescaler to 0 on any CTRL write.
REQ-021 SHALL let a software VALUE write take priority over a tick or match update in the same cycle.
REQ-022 SHALL let a hardware PEND set take priority over a same-cycle write-1-to-clear (PEND stays 1).
REQ-023 SHALL register read data: rd_data_o holds the register contents sampled at the edge where rd_req_i is high and the read is selected, valid the following cycle.
REQ-024 SHALL load rd_data_o with 0 when rd_req_i is high and the address is not selected.
REQ-025 SHALL hold rd_data_o unchanged while rd_req_i is low.
REQ-026 SHALL serve a read and a write in the same cycle independently; a read of a register being written returns the old value.
REQ-027 SHALL ignore writes whose address is not selected.

Reset
REQ-028 SHALL, on rst_n low, immediately clear CTRL, VALUE, STATUS, the prescaler, rd_data_o and int_o, and set CMP = 32'hFFFF_FFFF.
REQ-029 SHALL abort any count in progress on reset mid-operation; after release the timer stays idle until EN is written.

Verification
REQ-030 Write CMP=3, then CTRL=0x7 (EN, IE, AR, PSC=0) -> VALUE steps 0,1,2,3 over 4 cycles; on the next tick VALUE=0, PEND=1 and int_o=1; counting continues.
REQ-031 CTRL=0x103 (EN, IE, PSC=1, AR=0), CMP=2 -> VALUE advances every 2 cycles; on the match tick EN reads 0 and VALUE holds at 0.
REQ-032 With PEND=1, write STATUS=1 -> PEND=0 and int_o=0 next cycle. Repeat with the write coinciding with a match tick -> PEND remains 1.
REQ-033 Read VALUE at BASE+4 while counting -> rd_data_o, one cycle later, equals VALUE at the sampling edge. Read BASE+0x10 -> rd_data_o=0.
REQ-034 Write VALUE=32'hFFFF_FFFF with CMP=5 and EN=1 -> next tick VALUE=0 (wrap) and PEND stays 0. Also: write VALUE=0x10 on a tick cycle -> VALUE=0x10.
REQ-035 Assert rst_n low mid-count with int_o=1 -> all outputs 0 immediately, without waiting for a clock edge; CMP reads 32'hFFFF_FFFF after release.
